// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU opcode and arbiter FSM state constants
// Purpose: opcode encodings for the shared ALU and state encodings for the
//          alu_share_arbiter FSM. No ports.
package alu_defs;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - 32-bit combinational ALU
// Purpose: purely combinational ALU evaluated on the arbiter's latched operands.
// Ports:
//   a, b   : operands
//   op     : opcode (see alu_defs); undefined codes give 0
//   result : ALU result
module alu_share_arbiter_alu
  import alu_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // Unsigned compare: the operand path treats these as addresses.
      ALU_SLT: result = (a < b) ? DATA_W'(1) : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
// Purpose: arbitrates two requesters onto one ALU, one transaction in flight;
//          result held on the owner's response channel until consumed.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_op0/a0/b0       : requester 0 opcode and operands
//   req_op1/a1/b1       : requester 1 opcode and operands
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data, rsp_zero  : registered result and its zero flag
//   busy                : a transaction is in flight
module alu_share_arbiter
  import alu_defs::*;
#(
  parameter int   DATA_W  = 32,
  parameter logic RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2:0]        req_op0,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [2:0]        req_op1,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              busy
);

  logic [1:0]        state;
  logic              prio;
  logic              owner_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic [DATA_W-1:0] alu_result;
  logic [1:0]        grant;

  // Grant is only offered in IDLE, so the cycle that consumes a response can
  // never also accept a new request.
  always_comb begin
    grant = 2'b00;
    if (state == S_IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  alu_share_arbiter_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      prio     <= RR_INIT;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            owner_q <= grant[1];
            op_q    <= grant[1] ? req_op1 : req_op0;
            a_q     <= grant[1] ? req_a1  : req_a0;
            b_q     <= grant[1] ? req_b1  : req_b0;
            // Hand priority to the requester that just lost out.
            prio    <= ~grant[1];
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= alu_result;
          zero_q   <= (alu_result == '0);
          state    <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = result_q;
  // zero_q clears on reset, so the flag reads 0 until the first result lands.
  assign rsp_zero  = zero_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit combinational ALU between two requesters, for example the EX-stage operand path and a branch/address-compare unit.
- Round-robin arbitration picks a requester; its operands and opcode are latched and evaluated in one cycle.
- The result and zero flag are held on that requester's response channel until it is consumed.
- One transaction is in flight at a time. The ALU is instantiated inside this block.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  2  bit i = requester i presents a request
- req_ready  out  2  bit i = request i accepted this cycle
- req_op0  in  3  requester 0 opcode
- req_a0  in  32  requester 0 operand 1
- req_b0  in  32  requester 0 operand 2
- req_op1  in  3  requester 1 opcode
- req_a1  in  32  requester 1 operand 1
- req_b1  in  32  requester 1 operand 2
- rsp_valid  out  2  bit i = response for requester i is valid
- rsp_ready  in  2  bit i = requester i consumes its response
- rsp_data  out  32  result; meaningful only while a rsp_valid bit is high
- rsp_zero  out  1  result == 0
- busy  out  1  high when state != IDLE

Behaviour:
- Opcodes: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
  - All other codes are accepted and produce result 0, zero=1.
  - SLT is an unsigned compare; result is 1 or 0.
  - ADD/SUB wrap modulo 2^32.
- FSM states: IDLE, EXEC, RESP.
  - IDLE -> EXEC on a handshake (req_valid[i] & req_ready[i]).
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE when rsp_ready[owner] is high.
- Grant, combinational in IDLE only:
  - If only one req_valid bit is high, that requester is granted.
  - If both are high, the requester at the priority pointer (prio) is granted.
  - req_ready = grant when state == IDLE, else 2'b00.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- On handshake at edge N:
  - Latch op, a, b and owner index into internal registers.
  - prio <= ~owner.
- During EXEC (cycle N+1):
  - The ALU evaluates the latched operands.
  - Result and zero are registered at the end of that cycle.
- RESP, from cycle N+2:
  - rsp_valid[owner] = 1; the other bit = 0.
  - rsp_data and rsp_zero are stable until the handshake.
  - Minimum latency from accept to rsp_valid is 2 cycles.
- Response handshake:
  - When rsp_ready[owner] is high in RESP, the next state is IDLE.
  - No new request is accepted in that same cycle, so throughput is at most 1 transaction per 3 cycles.
  - rsp_ready of the non-owner is ignored.
- Simultaneous requests: strict alternation. With both requesters asserting continuously, grants go 0,1,0,1… when RR_INIT=0.
- A requester may drop req_valid before it is granted; nothing is latched for it.
- Reset values (async, immediate):
  - state=IDLE, prio=RR_INIT.
  - req_ready follows the grant logic in IDLE.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, busy=0.
  - Internal op/a/b/owner registers = 0.
- Reset during EXEC or RESP discards the transaction; no response is issued after reset release.
- X safety: rsp_zero is computed from the registered result, which is never X after reset.

Decomposition:
- Shared package/header (alu_defs) holds:
  - opcode constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - FSM state encodings S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2.
- One sub-module: the existing 32-bit ALU instance (inputs: latched a, b, op; output: result). The zero flag is derived locally from the registered result.
- The arbiter grant logic stays inline; no separate module.

Test Plan:
- Single request, requester 0, op=000, a=5, b=7, rsp_ready held high → req_ready[0] high in the accept cycle; rsp_valid=2'b01 two cycles later with rsp_data=12, rsp_zero=0; busy drops the cycle after.
- Both requesters valid continuously, RR_INIT=0; r0 issues SUB 9-9, r1 issues SLT 3<8 → grants in order 0,1,0,1. Responses: r0 gets 0 with zero=1, r1 gets 1 with zero=0. rsp_valid is one-hot each time.
- Backpressure: requester 1 issues OR 0xF0|0x0F, rsp_ready[1] low for 4 cycles → rsp_valid[1] and rsp_data=0xFF stable all 4 cycles. req_ready=00 throughout even with req_valid[0]=1. r0 is granted the cycle after the response handshake.
- Illegal op 3'b111, a=0xFFFFFFFF, b=1 → rsp_data=0, rsp_zero=1. ADD with the same operands → 0 (wrap), zero=1.
- Reset asserted in EXEC, released 2 cycles later → rsp_valid=00, busy=0 immediately on assertion. No response appears after release. With both requesters valid, the next grant goes to RR_INIT.
- Requester 0 raises req_valid for 1 cycle while state=RESP, then drops it → no transaction is accepted for r0 and the transaction count is unchanged.
